// File: rtl/led_banner_ctrl.sv
// LED banner driver: a step divider paces rotate, bounce and fill/drain animations
// across N LEDs, with one-cycle step and wrap pulses.
module led_banner_ctrl #(
    parameter int N     = 8,
    parameter int DIV_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_load,
    input  logic [N-1:0]     i_pattern,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_step_div,
    output logic [N-1:0]     o_led,
    output logic             o_step,
    output logic             o_wrap
);

    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic {PH_FILL, PH_DRAIN} phase_t;

    localparam logic [N-1:0] LED_ALL_ONES = {N{1'b1}};
    localparam logic [N-1:0] LED_RESET    = {{(N-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_cnt;
    logic [N-1:0]     r_led;
    dir_t             r_dir;
    phase_t           r_phase;
    logic [1:0]       r_mode;
    logic             r_step;
    logic             r_wrap;

    logic [DIV_W-1:0] w_cntNext;
    logic [N-1:0]     w_ledNext;
    dir_t             w_dirNext;
    phase_t           w_phaseNext;
    logic             w_stepNext;
    logic             w_wrapNext;
    logic             w_tick;
    logic             w_modeChg;
    dir_t             w_dirCur;
    phase_t           w_phaseCur;

    // A mode change restarts both sub-FSMs, and a step on that same edge already sees the restarted state.
    always_comb begin
        w_tick      = (r_cnt >= i_step_div);
        w_modeChg   = (i_mode != r_mode);
        w_dirCur    = w_modeChg ? DIR_LEFT : r_dir;
        w_phaseCur  = w_modeChg ? PH_FILL : r_phase;
        w_cntNext   = r_cnt;
        w_ledNext   = r_led;
        w_dirNext   = w_dirCur;
        w_phaseNext = w_phaseCur;
        w_stepNext  = 1'b0;
        w_wrapNext  = 1'b0;

        if (i_load) begin
            w_ledNext   = i_pattern;
            w_cntNext   = '0;
            w_dirNext   = DIR_LEFT;
            w_phaseNext = PH_FILL;
        end else if (i_run) begin
            if (w_tick) begin
                w_cntNext  = '0;
                w_stepNext = 1'b1;
                case (i_mode)
                    2'b00: begin
                        w_ledNext  = {r_led[N-2:0], r_led[N-1]};
                        w_wrapNext = r_led[N-1];
                    end
                    2'b01: begin
                        w_ledNext  = {r_led[0], r_led[N-1:1]};
                        w_wrapNext = r_led[0];
                    end
                    2'b10: begin
                        // An empty bar has nothing to bounce, so it keeps its direction.
                        if (r_led != '0) begin
                            if (w_dirCur == DIR_LEFT) begin
                                if (r_led[N-1]) begin
                                    w_dirNext  = DIR_RIGHT;
                                    w_ledNext  = {1'b0, r_led[N-1:1]};
                                    w_wrapNext = 1'b1;
                                end else begin
                                    w_ledNext = {r_led[N-2:0], 1'b0};
                                end
                            end else begin
                                if (r_led[0]) begin
                                    w_dirNext  = DIR_LEFT;
                                    w_ledNext  = {r_led[N-2:0], 1'b0};
                                    w_wrapNext = 1'b1;
                                end else begin
                                    w_ledNext = {1'b0, r_led[N-1:1]};
                                end
                            end
                        end
                    end
                    default: begin
                        if (w_phaseCur == PH_FILL) begin
                            if (r_led == LED_ALL_ONES) begin
                                w_phaseNext = PH_DRAIN;
                                w_ledNext   = {r_led[N-2:0], 1'b0};
                                w_wrapNext  = 1'b1;
                            end else begin
                                w_ledNext = {r_led[N-2:0], 1'b1};
                            end
                        end else begin
                            if (r_led == '0) begin
                                w_phaseNext = PH_FILL;
                                w_ledNext   = {r_led[N-2:0], 1'b1};
                                w_wrapNext  = 1'b1;
                            end else begin
                                w_ledNext = {r_led[N-2:0], 1'b0};
                            end
                        end
                    end
                endcase
            end else begin
                w_cntNext = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_led   <= LED_RESET;
            r_dir   <= DIR_LEFT;
            r_phase <= PH_FILL;
            r_mode  <= 2'b00;
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_cnt   <= w_cntNext;
            r_led   <= w_ledNext;
            r_dir   <= w_dirNext;
            r_phase <= w_phaseNext;
            r_mode  <= i_mode;
            r_step  <= w_stepNext;
            r_wrap  <= w_wrapNext;
        end
    end

    assign o_led  = r_led;
    assign o_step = r_step;
    assign o_wrap = r_wrap;

endmodule

// File: tb/tb_led_banner_ctrl.sv
// Scoreboard bench for led_banner_ctrl (N=8): a reference model queues the expected
// outputs as each cycle is driven, and they are popped and compared after the edge.
module tb_led_banner_ctrl;

    typedef struct packed {
        logic [7:0] led;
        logic       step;
        logic       wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        tRst = 1'b1;
    logic        tRun = 1'b0;
    logic        tLoad = 1'b0;
    logic [7:0]  tPat = 8'h00;
    logic [1:0]  tMode = 2'b00;
    logic [23:0] tDiv = 24'd0;
    logic [7:0]  ledOut;
    logic        stepOut;
    logic        wrapOut;

    int   assertCount = 0;
    int   failCount = 0;
    exp_t expQ[$];

    logic [7:0] mLed = 8'h01;
    int         mCnt = 0;
    bit         mDir = 1'b0;
    bit         mPhase = 1'b0;
    logic [1:0] mMode = 2'b00;

    led_banner_ctrl #(.N(8), .DIV_W(24)) dut (
        .i_clk(clk),
        .i_rst(tRst),
        .i_run(tRun),
        .i_load(tLoad),
        .i_pattern(tPat),
        .i_mode(tMode),
        .i_step_div(tDiv),
        .o_led(ledOut),
        .o_step(stepOut),
        .o_wrap(wrapOut)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge, written from the animation rules.
    task automatic modelUpdate();
        exp_t       e;
        logic [7:0] old;
        e = '0;
        if (tRst) begin
            mLed = 8'h01; mCnt = 0; mDir = 1'b0; mPhase = 1'b0; mMode = 2'b00;
        end else begin
            if (tMode != mMode) begin
                mDir = 1'b0; mPhase = 1'b0;
            end
            mMode = tMode;
            if (tLoad) begin
                mLed = tPat; mCnt = 0; mDir = 1'b0; mPhase = 1'b0;
            end else if (tRun) begin
                if (mCnt >= int'(tDiv)) begin
                    mCnt = 0;
                    e.step = 1'b1;
                    old = mLed;
                    case (tMode)
                        2'd0: begin mLed = (old << 1) | (old >> 7); e.wrap = old[7]; end
                        2'd1: begin mLed = (old >> 1) | (old << 7); e.wrap = old[0]; end
                        2'd2: begin
                            if (old != 8'h00) begin
                                if (!mDir && old[7])      begin mDir = 1'b1; mLed = old >> 1; e.wrap = 1'b1; end
                                else if (!mDir)           mLed = old << 1;
                                else if (old[0])          begin mDir = 1'b0; mLed = old << 1; e.wrap = 1'b1; end
                                else                      mLed = old >> 1;
                            end
                        end
                        default: begin
                            if (!mPhase && old == 8'hFF)      begin mPhase = 1'b1; mLed = 8'hFE; e.wrap = 1'b1; end
                            else if (!mPhase)                 mLed = (old << 1) | 8'h01;
                            else if (old == 8'h00)            begin mPhase = 1'b0; mLed = 8'h01; e.wrap = 1'b1; end
                            else                              mLed = old << 1;
                        end
                    endcase
                end else begin
                    mCnt++;
                end
            end
        end
        e.led = mLed;
        expQ.push_back(e);
    endtask

    // Runs the given number of clocks with the current inputs; load and reset last one clock.
    task automatic applyStimulus(input int cycles, input string sec);
        exp_t e;
        for (int c = 0; c < cycles; c++) begin
            modelUpdate();
            @(posedge clk);
            #1;
            if (expQ.size() == 0) begin
                checkOutput({sec, ".queue"}, 32'd0, 32'd1);
            end else begin
                e = expQ.pop_front();
                checkOutput({sec, ".led"}, 32'(ledOut), 32'(e.led));
                checkOutput({sec, ".step"}, 32'(stepOut), 32'(e.step));
                checkOutput({sec, ".wrap"}, 32'(wrapOut), 32'(e.wrap));
            end
            tLoad = 1'b0;
            tRst = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] fillSeq [17];
        logic [7:0] bounceSeq [16];
        logic [7:0] expLed;
        fillSeq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
        bounceSeq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                      8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

        #1;
        tRst = 1'b1;
        applyStimulus(2, "reset");
        checkOutput("reset.ledConst", 32'(ledOut), 32'h01);

        // Left rotation one step per clock.
        tRun = 1'b1; tMode = 2'b00; tDiv = 24'd0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, "rotL");
            expLed = 8'h01 << ((i + 1) % 8);
            checkOutput("rotL.ledConst", 32'(ledOut), 32'(expLed));
            checkOutput("rotL.wrapConst", 32'(wrapOut), (i == 7) ? 32'd1 : 32'd0);
        end

        // Right rotation every fourth clock.
        tLoad = 1'b1; tPat = 8'h81; tMode = 2'b01; tDiv = 24'd3;
        applyStimulus(1, "rotRload");
        applyStimulus(4, "rotR");
        checkOutput("rotR.c0", 32'(ledOut), 32'hC0);
        applyStimulus(8, "rotR");
        checkOutput("rotR.30", 32'(ledOut), 32'h30);

        // Bounce sweep, then an empty bar that still pulses step.
        tLoad = 1'b1; tPat = 8'h01; tMode = 2'b10; tDiv = 24'd0;
        applyStimulus(1, "bounceLoad");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, "bounce");
            checkOutput("bounce.ledConst", 32'(ledOut), 32'(bounceSeq[i]));
        end
        tLoad = 1'b1; tPat = 8'h00;
        applyStimulus(1, "bounceZeroLoad");
        applyStimulus(3, "bounceZero");
        checkOutput("bounceZero.stepConst", 32'(stepOut), 32'd1);

        // Fill then drain.
        tLoad = 1'b1; tPat = 8'h00; tMode = 2'b11;
        applyStimulus(1, "fillLoad");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, "fill");
            checkOutput("fill.ledConst", 32'(ledOut), 32'(fillSeq[i]));
        end

        // Load colliding with a tick, a freeze, then a divider raised mid-count.
        tLoad = 1'b1; tPat = 8'hA5; tMode = 2'b00; tDiv = 24'd0;
        applyStimulus(1, "loadTick");
        checkOutput("loadTick.stepConst", 32'(stepOut), 32'd0);
        tRun = 1'b0;
        applyStimulus(10, "freeze");
        checkOutput("freeze.ledConst", 32'(ledOut), 32'hA5);
        tRun = 1'b1; tDiv = 24'd2;
        applyStimulus(2, "divLow");
        tDiv = 24'd9;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1, "divHigh");
            checkOutput("divHigh.stepConst", 32'(stepOut), (k == 8) ? 32'd1 : 32'd0);
        end
        checkOutput("divHigh.ledConst", 32'(ledOut), 32'h4B);

        // Reset in the middle of a rightward bounce.
        tLoad = 1'b1; tPat = 8'h01; tMode = 2'b10; tDiv = 24'd0;
        applyStimulus(1, "midRstLoad");
        applyStimulus(10, "midRstSweep");
        checkOutput("midRst.preLed", 32'(ledOut), 32'h10);
        tRst = 1'b1;
        applyStimulus(1, "midRst");
        checkOutput("midRst.ledConst", 32'(ledOut), 32'h01);
        checkOutput("midRst.stepConst", 32'(stepOut), 32'd0);
        applyStimulus(1, "midRstResume");
        checkOutput("midRst.resumeConst", 32'(ledOut), 32'h02);

        // Random mix of run, load, reset, mode and divider changes.
        for (int i = 0; i < 120; i++) begin
            tRun = ($urandom_range(0, 9) < 8);
            tLoad = ($urandom_range(0, 9) == 0);
            tRst = ($urandom_range(0, 39) == 0);
            tPat = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) tMode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) tDiv = 24'($urandom_range(0, 3));
            applyStimulus(1, "random");
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
